ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

PS/2 keyboard receiver and key decoder for the plane game. It samples the raw `ps2_clk`/`ps2_data` pins, assembles 11-bit device-to-host frames and interprets set-2 make/break/extended scan codes. It drives the four held direction levels consumed by the player-plane movement logic, and a one-cycle `enter` pulse that arms gameplay in the top level. It runs entirely in the 100 MHz system clock domain.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronized samples required before `ps2_clk` changes filtered level.
- `TIMEOUT`, default 200000: idle cycles mid-frame (2 ms at 100 MHz) after which a partial frame is abandoned.
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: reset, asynchronous, active-high.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `up` output 1: level, high while W (0x1D) or Up arrow (E0 75) is held.
- `down` output 1: level, high while S (0x1B) or Down arrow (E0 72) is held.
- `left` output 1: level, high while A (0x1C) or Left arrow (E0 6B) is held.
- `right` output 1: level, high while D (0x23) or Right arrow (E0 74) is held.
- `enter` output 1: one-cycle pulse on the initial make of Enter (0x5A or E0 5A).
- `frame_err` output 1: one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Input conditioning:
  - Both pins pass through 2-FF synchronizers.
  - The synchronized clock feeds a saturating filter counter. The filtered level changes only after `FILTER_LEN` equal samples.
  - A falling edge of the filtered clock produces a one-cycle `fall` strobe. Data is sampled on `fall`.
- Receiver FSM:
  - IDLE: on `fall`, if data=0 go to DATA with bit count 0. If data=1, pulse `frame_err` and stay in IDLE.
  - DATA: shift in 8 bits LSB first on successive `fall`s, then go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, the frame is valid if stop=1 and the XOR of the 8 data bits plus parity is 1 (odd parity). A valid frame pulses `byte_valid` with the byte. An invalid frame pulses `frame_err`. Either way, return to IDLE.
  - Timeout: a timeout counter resets on each `fall` and counts in every non-IDLE state. When it reaches `TIMEOUT`, pulse `frame_err` and return to IDLE.
- Decoder, acting on `byte_valid`:
  - 0xE0 sets `ext`. 0xF0 sets `brk`. No other effect.
  - Any other code ends the sequence. Look up the code under `ext`:
    - Mapped direction: its held flag takes the value `!brk`.
    - Enter make: pulse `enter` only if `enter_held` is 0, then set `enter_held`.
    - Enter break: clear `enter_held`.
    - Unmapped code: ignored.
  - After any non-prefix code, clear `ext` and `brk`.
- Extended/non-extended aliases share one output. Up and W are ORed, using two independent held bits per direction.
- Any `frame_err` clears `ext` and `brk`. Held key bits are kept.
- The block has no host-to-device transmit path. It never drives `ps2_clk` or `ps2_data`.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE; counters 0.
  - Synchronizers and filtered clock at 1.
  - `ext`, `brk`, held bits and `enter_held` all 0.
- Latency:
  - Raw falling edge of `ps2_clk` to `fall`: 2 + `FILTER_LEN` cycles.
  - `fall` on the stop bit to `byte_valid`: 1 cycle.
  - `byte_valid` to direction level change or `enter` pulse: 1 cycle.
- `enter` and `frame_err` are exactly one cycle wide.
- Typematic repeat makes hold levels unchanged and produce no extra `enter` pulse.
- Glitches shorter than `FILTER_LEN` cycles on `ps2_clk` produce no `fall`.
- Asynchronous `rst` mid-frame discards the partial byte and all held state immediately. Decoding resumes with the next start bit.
- The same direction pressed and released in consecutive frames gives a level high for exactly the span between the two code bytes' `byte_valid` + 1.

## Test plan
- Send frame 0x1D (W make) at a 12.5 kHz bit rate → `up`=1 one cycle after the stop-bit `fall`. Send F0 1D → `up`=0. Other outputs stay 0 throughout.
- Send E0 75, then 1D, then E0 F0 75 → `up` stays 1 after the arrow break (W still held). Then F0 1D → `up`=0.
- Send 5A, 5A, 5A (typematic), then F0 5A, then 5A → exactly two `enter` pulses, each one cycle wide.
- Send 0x1C with the parity bit inverted → one `frame_err` pulse and `left` stays 0. The next good 0x1C → `left`=1.
- Send start bit plus 4 data bits, then hold `ps2_clk` high for 200001 cycles → `frame_err` pulses. A following full 0x23 frame → `right`=1.
- Send 0x1B, then assert `rst` mid-way through F0 → `down`=0 during reset, FSM in IDLE. After release, a clean 0x1B → `down`=1. Also inject 3-cycle low glitches on `ps2_clk` between bits → no bit slips and byte decoded correctly.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and set-2 scan-code decoder for the plane game.
// Drives held direction levels plus one-cycle enter and frame_err pulses.
module ps2_key_decoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 200000
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic enter,
   output logic frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    csync, dsync;
   logic [FW-1:0] fcnt;
   logic          filt, fall;

   state_t        state;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg, rx_byte;
   logic          par, byte_valid;
   logic [TW-1:0] tcnt;

   logic          ext, brk, enter_held;
   logic [7:0]    held;
   logic          hit, is_enter;
   logic [2:0]    dir;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csync <= 2'b11;
         dsync <= 2'b11;
         fcnt  <= '0;
         filt  <= 1'b1;
         fall  <= 1'b0;
      end else begin
         csync <= {csync[0], ps2_clk};
         dsync <= {dsync[0], ps2_data};
         fall  <= 1'b0;
         // level only moves after FILTER_LEN consecutive differing samples
         if (csync[1] == filt) begin
            fcnt <= '0;
         end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            fcnt <= '0;
            filt <= csync[1];
            fall <= filt;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bitcnt     <= '0;
         shreg      <= '0;
         rx_byte    <= '0;
         par        <= 1'b0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         tcnt       <= '0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (state != IDLE && !fall && tcnt == TW'(TIMEOUT - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            tcnt      <= '0;
         end else begin
            if (fall || state == IDLE) tcnt <= '0;
            else                       tcnt <= tcnt + 1'b1;
            if (fall) begin
               unique case (state)
                  IDLE: begin
                     if (!dsync[1]) begin
                        state  <= DATA;
                        bitcnt <= '0;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
                  DATA: begin
                     shreg  <= {dsync[1], shreg[7:1]};
                     bitcnt <= bitcnt + 1'b1;
                     if (bitcnt == 3'd7) state <= PARITY;
                  end
                  PARITY: begin
                     par   <= dsync[1];
                     state <= STOP;
                  end
                  STOP: begin
                     if (dsync[1] && ((^shreg) ^ par)) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shreg;
                     end else begin
                        frame_err <= 1'b1;
                     end
                     state <= IDLE;
                  end
               endcase
            end
         end
      end
   end

   // held[3:0]: W S A D, held[7:4]: arrow aliases
   always_comb begin
      hit      = 1'b0;
      is_enter = 1'b0;
      dir      = 3'd0;
      case ({ext, rx_byte})
         9'h01D: begin hit = 1'b1; dir = 3'd0; end
         9'h01B: begin hit = 1'b1; dir = 3'd1; end
         9'h01C: begin hit = 1'b1; dir = 3'd2; end
         9'h023: begin hit = 1'b1; dir = 3'd3; end
         9'h175: begin hit = 1'b1; dir = 3'd4; end
         9'h172: begin hit = 1'b1; dir = 3'd5; end
         9'h16B: begin hit = 1'b1; dir = 3'd6; end
         9'h174: begin hit = 1'b1; dir = 3'd7; end
         9'h05A, 9'h15A: is_enter = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext        <= 1'b0;
         brk        <= 1'b0;
         enter_held <= 1'b0;
         held       <= '0;
         enter      <= 1'b0;
      end else begin
         enter <= 1'b0;
         if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_valid) begin
            if (rx_byte == 8'hE0) begin
               ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (hit) held[dir] <= !brk;
               if (is_enter) begin
                  if (brk) begin
                     enter_held <= 1'b0;
                  end else begin
                     enter      <= !enter_held;
                     enter_held <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign up    = held[0] | held[4];
   assign down  = held[1] | held[5];
   assign left  = held[2] | held[6];
   assign right = held[3] | held[7];
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: frame table plus timeout, reset and glitch
// sequences, with an expected-result queue and pulse monitors.
module tb_ps2_key_decoder;
   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 2000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   logic up, down, left, right, enter, frame_err;

   ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .up(up), .down(down), .left(left), .right(right),
      .enter(enter), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] code;
      bit         badpar;
      bit         badstop;
      logic [3:0] dir;
      int         ent;
      int         err;
   } vec_t;

   typedef struct {
      logic [3:0] dir;
      int         ent;
      int         err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;
   int ent_cnt  = 0;
   int err_cnt  = 0;
   int wide_cnt = 0;
   logic enter_q = 1'b0;
   logic err_q   = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         if (enter) ent_cnt <= ent_cnt + 1;
         if (frame_err) err_cnt <= err_cnt + 1;
         if ((enter && enter_q) || (frame_err && err_q))
            wide_cnt <= wide_cnt + 1;
      end
      enter_q <= enter;
      err_q   <= frame_err;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic b, input bit glitch);
      ps2_data = b;
      cyc(10);
      if (glitch) begin
         ps2_clk = 1'b0;
         cyc(3);
         ps2_clk = 1'b1;
         cyc(4);
      end
      ps2_clk = 1'b0;
      cyc(20);
      ps2_clk = 1'b1;
      cyc(10);
   endtask

   task automatic send(input logic [7:0] code, input bit badpar,
                       input bit badstop, input bit glitch);
      ps2_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) ps2_bit(code[i], glitch);
      ps2_bit((~^code) ^ badpar, glitch);
      ps2_bit(!badstop, glitch);
      ps2_data = 1'b1;
      cyc(60);
   endtask

   task automatic pop_cmp(input string name, input int e0, input int r0);
      exp_t e;
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check({name, "_dir"}, {28'd0, up, down, left, right}, {28'd0, e.dir});
      check({name, "_enter"}, ent_cnt - e0, e.ent);
      check({name, "_err"}, err_cnt - r0, e.err);
   endtask

   task automatic run(input string name, input logic [7:0] code,
                      input bit badpar, input bit badstop, input bit glitch,
                      input logic [3:0] dir, input int ent, input int err);
      int e0, r0;
      e0 = ent_cnt;
      r0 = err_cnt;
      sb.push_back('{dir, ent, err});
      send(code, badpar, badstop, glitch);
      pop_cmp(name, e0, r0);
   endtask

   function automatic void add(input logic [7:0] c, input bit bp,
                               input bit bs, input logic [3:0] d,
                               input int en, input int er);
      vecs.push_back('{c, bp, bs, d, en, er});
   endfunction

   initial begin
      int e0, r0;
      // dir order {up, down, left, right}
      add(8'h1D, 0, 0, 4'b1000, 0, 0);
      add(8'hF0, 0, 0, 4'b1000, 0, 0);
      add(8'h1D, 0, 0, 4'b0000, 0, 0);
      add(8'hE0, 0, 0, 4'b0000, 0, 0);
      add(8'h75, 0, 0, 4'b1000, 0, 0);
      add(8'h1D, 0, 0, 4'b1000, 0, 0);
      add(8'hE0, 0, 0, 4'b1000, 0, 0);
      add(8'hF0, 0, 0, 4'b1000, 0, 0);
      add(8'h75, 0, 0, 4'b1000, 0, 0);
      add(8'hF0, 0, 0, 4'b1000, 0, 0);
      add(8'h1D, 0, 0, 4'b0000, 0, 0);
      add(8'h5A, 0, 0, 4'b0000, 1, 0);
      add(8'h5A, 0, 0, 4'b0000, 0, 0);
      add(8'h5A, 0, 0, 4'b0000, 0, 0);
      add(8'hF0, 0, 0, 4'b0000, 0, 0);
      add(8'h5A, 0, 0, 4'b0000, 0, 0);
      add(8'h5A, 0, 0, 4'b0000, 1, 0);
      add(8'hE0, 0, 0, 4'b0000, 0, 0);
      add(8'hF0, 0, 0, 4'b0000, 0, 0);
      add(8'h5A, 0, 0, 4'b0000, 0, 0);
      add(8'hE0, 0, 0, 4'b0000, 0, 0);
      add(8'h5A, 0, 0, 4'b0000, 1, 0);
      add(8'h1C, 1, 0, 4'b0000, 0, 1);
      add(8'h1C, 0, 0, 4'b0010, 0, 0);
      add(8'hF0, 0, 0, 4'b0010, 0, 0);
      add(8'h1C, 0, 0, 4'b0000, 0, 0);
      add(8'hE0, 0, 0, 4'b0000, 0, 0);
      add(8'h00, 0, 1, 4'b0000, 0, 1);
      add(8'h72, 0, 0, 4'b0000, 0, 0);
      add(8'hE0, 0, 0, 4'b0000, 0, 0);
      add(8'h72, 0, 0, 4'b0100, 0, 0);
      add(8'hE0, 0, 0, 4'b0100, 0, 0);
      add(8'hF0, 0, 0, 4'b0100, 0, 0);
      add(8'h72, 0, 0, 4'b0000, 0, 0);
      add(8'hE0, 0, 0, 4'b0000, 0, 0);
      add(8'h6B, 0, 0, 4'b0010, 0, 0);
      add(8'hE0, 0, 0, 4'b0010, 0, 0);
      add(8'h74, 0, 0, 4'b0011, 0, 0);
      add(8'hE0, 0, 0, 4'b0011, 0, 0);
      add(8'hF0, 0, 0, 4'b0011, 0, 0);
      add(8'h6B, 0, 0, 4'b0001, 0, 0);
      add(8'hE0, 0, 0, 4'b0001, 0, 0);
      add(8'hF0, 0, 0, 4'b0001, 0, 0);
      add(8'h74, 0, 0, 4'b0000, 0, 0);

      cyc(5);
      check("reset_outputs", {26'd0, up, down, left, right, enter, frame_err},
            32'd0);
      rst = 1'b0;
      cyc(20);

      for (int i = 0; i < vecs.size(); i++)
         run($sformatf("vec%0d_%02h", i, vecs[i].code), vecs[i].code,
             vecs[i].badpar, vecs[i].badstop, 1'b0,
             vecs[i].dir, vecs[i].ent, vecs[i].err);

      // partial frame abandoned by timeout
      e0 = ent_cnt;
      r0 = err_cnt;
      sb.push_back('{4'b0000, 0, 1});
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
      ps2_data = 1'b1;
      cyc(TIMEOUT + 50);
      pop_cmp("timeout", e0, r0);
      run("after_to_23", 8'h23, 0, 0, 0, 4'b0001, 0, 0);
      run("after_to_f0", 8'hF0, 0, 0, 0, 4'b0001, 0, 0);
      run("after_to_rel", 8'h23, 0, 0, 0, 4'b0000, 0, 0);

      // reset mid-frame discards held state
      run("pre_rst_1b", 8'h1B, 0, 0, 0, 4'b0100, 0, 0);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b0, 1'b0);
      rst = 1'b1;
      cyc(3);
      check("in_reset_outputs",
            {26'd0, up, down, left, right, enter, frame_err}, 32'd0);
      rst = 1'b0;
      ps2_data = 1'b1;
      cyc(100);
      check("post_rst_down", {31'd0, down}, 32'd0);
      run("glitch_1b", 8'h1B, 0, 0, 1, 4'b0100, 0, 0);
      run("glitch_f0", 8'hF0, 0, 0, 1, 4'b0100, 0, 0);
      run("glitch_rel", 8'h1B, 0, 0, 1, 4'b0000, 0, 0);

      check("pulse_width", wide_cnt, 32'd0);
      check("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
